// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and round-robin helper for the UART TX scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } tx_sched_state_e;

    localparam int RR_MAX_REQ = 32;

    // First set bit of mask strictly after ptr, wrapping at n; returns ptr if mask is empty.
    function automatic int rr_next(input logic [RR_MAX_REQ-1:0] mask, input int n, input int ptr);
        int   idx;
        logic found;
        rr_next = ptr;
        found   = 1'b0;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            idx = (ptr + k) % n;
            if (k <= n && !found && mask[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin next-grant from request mask and pointer.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_any
);

    logic [RR_MAX_REQ-1:0] w_mask;

    always_comb begin
        w_mask          = '0;
        w_mask[N-1:0]   = i_req;
        o_grant         = IDX_W'(rr_next(w_mask, N, int'(i_ptr)));
        o_any           = |i_req;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_sched
// Brief   : Round-robin scheduler sharing one uart_tx among NUM_REQ producers.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = 8,
    parameter int GAP_TICKS     = 1,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [NUM_REQ-1:0]             req_drop,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           sched_busy
);

    localparam int c_idx_w   = $clog2(NUM_REQ);
    localparam int c_cnt_max = (GAP_TICKS > START_TIMEOUT) ? GAP_TICKS : START_TIMEOUT;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(START_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    logic [DATA_BITS-1:0] w_bytes [NUM_REQ];
    logic [c_idx_w-1:0]   w_grant;
    logic                 w_any;

    tx_sched_state_e      r_state;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_idx_w-1:0]   r_grant;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_busy_q;
    logic                 r_tx_start;
    logic [DATA_BITS-1:0] r_tx_data;
    logic [NUM_REQ-1:0]   r_ready;
    logic [NUM_REQ-1:0]   r_done;
    logic [NUM_REQ-1:0]   r_drop;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_bytes[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (c_idx_w)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= c_idx_w'(NUM_REQ - 1);
            r_grant    <= '0;
            r_cnt      <= '0;
            r_busy_q   <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_ready    <= '0;
            r_done     <= '0;
            r_drop     <= '0;
        end else begin
            r_ready  <= '0;
            r_done   <= '0;
            r_drop   <= '0;
            r_busy_q <= tx_busy;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ready    <= NUM_REQ'(1) << w_grant;
                        r_tx_data  <= w_bytes[w_grant];
                        r_grant    <= w_grant;
                        r_ptr      <= w_grant;
                        r_cnt      <= '0;
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    // A busy seen in the same cycle as the last timeout tick still counts as a start.
                    if (tx_busy) begin
                        r_tx_start <= 1'b0;
                        r_state    <= S_WAIT;
                    end else if (tick) begin
                        if (r_cnt == c_to_last) begin
                            r_tx_start <= 1'b0;
                            r_drop     <= NUM_REQ'(1) << r_grant;
                            r_cnt      <= '0;
                            r_state    <= S_GAP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (tx_done || (r_busy_q && !tx_busy)) begin
                        r_done  <= NUM_REQ'(1) << r_grant;
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (GAP_TICKS == 0) begin
                        r_state <= S_IDLE;
                    end else if (tick) begin
                        if (r_cnt == c_gap_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign req_done   = r_done;
    assign req_drop   = r_drop;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign grant_id   = r_grant;
    assign sched_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_sched
// Brief   : Directed self-checking bench for uart_tx_sched with a uart_tx model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

    localparam int NR          = 4;
    localparam int DB          = 8;
    localparam int FRAME_TICKS = 10;
    localparam int TICK_DIV    = 4;
    localparam int BUDGET      = 3000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tick = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*DB-1:0] req_data = '0;
    logic [NR-1:0]  req_ready, req_done, req_drop;
    logic           tx_start;
    logic [DB-1:0]  tx_data;
    logic           tx_busy, tx_done;
    logic [1:0]     grant_id;
    logic           sched_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    int tick_div = 0;
    always @(posedge clk) begin
        tick_div <= (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
        tick     <= (tick_div == TICK_DIV - 1);
    end

    uart_tx_sched #(
        .NUM_REQ(NR), .DATA_BITS(DB), .GAP_TICKS(1), .START_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .req_done(req_done), .req_drop(req_drop),
        .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_id(grant_id), .sched_busy(sched_busy)
    );

    // uart_tx stand-in: starts on tx_start when CTS is high, busy for FRAME_TICKS ticks.
    logic          cts = 1'b1;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [DB-1:0] m_byte = '0;
    int            m_ticks = 0;
    int            model_err = 0;
    logic [DB-1:0] frame_q[$];

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_busy  <= 1'b0;
            m_ticks <= 0;
        end else if (!m_busy) begin
            if (tx_start && cts) begin
                m_busy  <= 1'b1;
                m_byte  <= tx_data;
                m_ticks <= 0;
                frame_q.push_back(tx_data);
            end
        end else begin
            if (tx_data !== m_byte) model_err++;
            if (tick) begin
                if (m_ticks == FRAME_TICKS - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_ticks <= m_ticks + 1;
                end
            end
        end
    end
    assign tx_busy = m_busy;
    assign tx_done = m_done;

    int   ready_seq[$];
    int   gap_q[$];
    int   done_cnt[NR];
    int   drop_cnt[NR];
    int   pulse_err = 0;
    int   gap_ticks = 0;
    int   start_ticks = 0;
    int   last_start_ticks = 0;
    logic prev_start = 1'b0;

    initial begin
        for (int i = 0; i < NR; i++) begin
            done_cnt[i] = 0;
            drop_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        if ($countones(req_ready) + $countones(req_done) + $countones(req_drop) > 1) pulse_err++;
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                ready_seq.push_back(i);
                gap_q.push_back(gap_ticks);
            end
            if (req_done[i]) done_cnt[i]++;
            if (req_drop[i]) drop_cnt[i]++;
        end
        if (|req_done) gap_ticks = tick ? 1 : 0;
        else           gap_ticks += int'(tick);
        if (tx_start) begin
            start_ticks += int'(tick);
        end else if (prev_start) begin
            last_start_ticks = start_ticks;
            start_ticks      = 0;
        end
        prev_start = tx_start;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; req_valid = '0; cts = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_ready(input int target, input string name);
        int n = 0;
        while (ready_seq.size() < target && n <= BUDGET) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (ready_seq.size() < target) begin
            failures++;
            $display("FAIL %s ready_timeout: accepts=%0d required=%0d", name, ready_seq.size(), target);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk); #1;
        while ((sched_busy || tx_busy) && n <= BUDGET) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (sched_busy || tx_busy) begin
            failures++;
            $display("FAIL %s idle_timeout: sched_busy=%0b required=0", name, sched_busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk); #1;
        checks++; if (tx_start !== 1'b0)   begin failures++; $display("FAIL reset_tx_start: got=%0b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00)   begin failures++; $display("FAIL reset_tx_data: got=%02h exp=00", tx_data); end
        checks++; if (req_ready !== 4'h0)  begin failures++; $display("FAIL reset_ready: got=%b exp=0000", req_ready); end
        checks++; if (req_done !== 4'h0)   begin failures++; $display("FAIL reset_done: got=%b exp=0000", req_done); end
        checks++; if (req_drop !== 4'h0)   begin failures++; $display("FAIL reset_drop: got=%b exp=0000", req_drop); end
        checks++; if (grant_id !== 2'd0)   begin failures++; $display("FAIL reset_grant: got=%0d exp=0", grant_id); end
        checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got=%0b exp=0", sched_busy); end
    endtask

    task automatic test_single();
        int base = ready_seq.size();
        int fb   = frame_q.size();
        int d2   = done_cnt[2];
        req_data[2*DB +: DB] = 8'h55;
        req_valid = 4'b0100;
        wait_ready(base + 1, "single");
        req_valid = '0;
        checks++; if (ready_seq.size() > base && ready_seq[base] != 2) begin failures++; $display("FAIL single_ready_id: got=%0d exp=2", ready_seq[base]); end
        checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_grant: got=%0d exp=2", grant_id); end
        wait_idle("single");
        checks++; if (frame_q.size() != fb + 1 || frame_q[frame_q.size()-1] !== 8'h55) begin failures++; $display("FAIL single_frame: frames=%0d exp=%0d", frame_q.size(), fb + 1); end
        checks++; if (done_cnt[2] != d2 + 1) begin failures++; $display("FAIL single_done: got=%0d exp=%0d", done_cnt[2], d2 + 1); end
    endtask

    task automatic test_round_robin();
        int            exp_id[5]   = '{0, 1, 2, 3, 0};
        logic [DB-1:0] exp_byte[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        int base, fb, d0;
        do_reset();
        base = ready_seq.size();
        fb   = frame_q.size();
        d0   = done_cnt[0];
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        wait_ready(base + 5, "rr");
        req_valid = '0;
        wait_idle("rr");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ready_seq.size() <= base + k || ready_seq[base+k] != exp_id[k]) begin
                failures++; $display("FAIL rr_order[%0d]: got=%0d exp=%0d", k, (ready_seq.size() > base + k) ? ready_seq[base+k] : -1, exp_id[k]);
            end
            checks++;
            if (frame_q.size() <= fb + k || frame_q[fb+k] !== exp_byte[k]) begin
                failures++; $display("FAIL rr_frame[%0d]: exp=%02h", k, exp_byte[k]);
            end
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (gap_q.size() <= base + k || gap_q[base+k] < 1) begin
                failures++; $display("FAIL rr_gap[%0d]: got=%0d exp>=1", k, (gap_q.size() > base + k) ? gap_q[base+k] : -1);
            end
        end
        checks++; if (done_cnt[0] != d0 + 2) begin failures++; $display("FAIL rr_done0: got=%0d exp=%0d", done_cnt[0], d0 + 2); end
    endtask

    task automatic test_timeout();
        int base, fb, dr1, dn1;
        int n = 0;
        do_reset();
        base = ready_seq.size();
        fb   = frame_q.size();
        dr1  = drop_cnt[1];
        dn1  = done_cnt[1];
        cts = 1'b0;
        req_data[1*DB +: DB] = 8'h77;
        req_data[2*DB +: DB] = 8'h99;
        req_valid = 4'b0110;
        wait_ready(base + 1, "timeout");
        req_valid = 4'b0100;
        while (drop_cnt[1] == dr1 && n <= BUDGET) begin
            @(negedge clk); #1;
            n++;
        end
        cts = 1'b1;
        checks++; if (drop_cnt[1] != dr1 + 1) begin failures++; $display("FAIL timeout_drop1: got=%0d exp=%0d", drop_cnt[1], dr1 + 1); end
        checks++; if (last_start_ticks != 16) begin failures++; $display("FAIL timeout_start_ticks: got=%0d exp=16", last_start_ticks); end
        wait_ready(base + 2, "timeout_next");
        req_valid = '0;
        wait_idle("timeout");
        checks++; if (ready_seq.size() > base + 1 && ready_seq[base+1] != 2) begin failures++; $display("FAIL timeout_next_id: got=%0d exp=2", ready_seq[base+1]); end
        checks++; if (done_cnt[1] != dn1) begin failures++; $display("FAIL timeout_no_done1: got=%0d exp=%0d", done_cnt[1], dn1); end
        checks++; if (frame_q.size() != fb + 1 || frame_q[frame_q.size()-1] !== 8'h99) begin failures++; $display("FAIL timeout_next_frame: frames=%0d exp=%0d", frame_q.size(), fb + 1); end
    endtask

    task automatic test_cts_delay();
        int base, fb, dr0, dn0;
        int t = 0;
        do_reset();
        base = ready_seq.size();
        fb   = frame_q.size();
        dr0  = drop_cnt[0];
        dn0  = done_cnt[0];
        cts = 1'b0;
        req_data[0 +: DB] = 8'hA5;
        req_valid = 4'b0001;
        wait_ready(base + 1, "cts");
        req_valid = '0;
        while (t < 5) begin
            @(negedge clk); #1;
            t += int'(tick);
        end
        cts = 1'b1;
        wait_idle("cts");
        checks++; if (drop_cnt[0] != dr0) begin failures++; $display("FAIL cts_no_drop: got=%0d exp=%0d", drop_cnt[0], dr0); end
        checks++; if (done_cnt[0] != dn0 + 1) begin failures++; $display("FAIL cts_done: got=%0d exp=%0d", done_cnt[0], dn0 + 1); end
        checks++; if (last_start_ticks != 5) begin failures++; $display("FAIL cts_start_ticks: got=%0d exp=5", last_start_ticks); end
        checks++; if (frame_q.size() != fb + 1 || frame_q[frame_q.size()-1] !== 8'hA5) begin failures++; $display("FAIL cts_frame: frames=%0d exp=%0d", frame_q.size(), fb + 1); end
    endtask

    task automatic test_reset_midframe();
        int base, fb, d2;
        int n = 0;
        do_reset();
        req_data[2*DB +: DB] = 8'h3C;
        req_valid = 4'b0100;
        while (!tx_busy && n <= BUDGET) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (5) @(negedge clk);
        d2 = done_cnt[2];
        @(posedge clk); #1;
        rst = 1'b1;
        req_data[0 +: DB] = 8'h5A;
        req_valid = 4'b0101;
        @(posedge clk);
        @(negedge clk); #1;
        checks++; if (tx_start !== 1'b0)   begin failures++; $display("FAIL midrst_tx_start: got=%0b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00)   begin failures++; $display("FAIL midrst_tx_data: got=%02h exp=00", tx_data); end
        checks++; if (grant_id !== 2'd0)   begin failures++; $display("FAIL midrst_grant: got=%0d exp=0", grant_id); end
        checks++; if (sched_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got=%0b exp=0", sched_busy); end
        checks++; if ((req_ready | req_done | req_drop) !== 4'h0) begin failures++; $display("FAIL midrst_pulses: got=%b exp=0000", req_ready | req_done | req_drop); end
        base = ready_seq.size();
        fb   = frame_q.size();
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready(base + 1, "midrst");
        req_valid = '0;
        checks++; if (ready_seq.size() > base && ready_seq[base] != 0) begin failures++; $display("FAIL midrst_first_id: got=%0d exp=0", ready_seq[base]); end
        wait_idle("midrst");
        checks++; if (done_cnt[2] != d2) begin failures++; $display("FAIL midrst_no_done2: got=%0d exp=%0d", done_cnt[2], d2); end
        checks++; if (frame_q.size() != fb + 1 || frame_q[frame_q.size()-1] !== 8'h5A) begin failures++; $display("FAIL midrst_frame: frames=%0d exp=%0d", frame_q.size(), fb + 1); end
    endtask

    task automatic test_back_to_back();
        int            exp_id[4]   = '{3, 0, 1, 0};
        logic [DB-1:0] exp_byte[4] = '{8'hC3, 8'hD0, 8'hD1, 8'hD0};
        int base, fb;
        do_reset();
        base = ready_seq.size();
        fb   = frame_q.size();
        req_data[3*DB +: DB] = 8'hC3;
        req_valid = 4'b1000;
        wait_ready(base + 1, "b2b");
        @(negedge clk); #1;
        req_data  = {8'hFF, 8'h00, 8'hD1, 8'hD0};
        req_valid = 4'b0011;
        wait_ready(base + 4, "b2b");
        req_valid = '0;
        wait_idle("b2b");
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ready_seq.size() <= base + k || ready_seq[base+k] != exp_id[k]) begin
                failures++; $display("FAIL b2b_order[%0d]: got=%0d exp=%0d", k, (ready_seq.size() > base + k) ? ready_seq[base+k] : -1, exp_id[k]);
            end
            checks++;
            if (frame_q.size() <= fb + k || frame_q[fb+k] !== exp_byte[k]) begin
                failures++; $display("FAIL b2b_frame[%0d]: exp=%02h", k, exp_byte[k]);
            end
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_cts_delay();
        test_reset_midframe();
        test_back_to_back();
        checks++; if (pulse_err != 0) begin failures++; $display("FAIL pulse_onehot: got=%0d exp=0", pulse_err); end
        checks++; if (model_err != 0) begin failures++; $display("FAIL tx_data_stable: got=%0d exp=0", model_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
